// File: rtl/pio_edge_irq_pkg.sv
// Shared constants for the multi-channel edge-capturing input PIO.
// Word addresses of the Avalon-MM register map and the data bus width.
package pio_edge_irq_pkg;

   localparam int BUS_W = 32;

   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_RISE = 3'd1;
   localparam logic [2:0] ADDR_MASK = 3'd2;
   localparam logic [2:0] ADDR_CAPT = 3'd3;
   localparam logic [2:0] ADDR_FALL = 3'd4;
   localparam logic [2:0] ADDR_DBNC = 3'd5;

   typedef logic [BUS_W-1:0] bus_t;

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: two-flop synchroniser, counter-based debounce filter,
// and a delayed copy of the filtered level for edge detection.
module pio_debounce_ch #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_i,
   input  logic [CNT_W-1:0] dbnc_i,
   input  logic             cnt_clr_i,
   output logic             filt_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic             s1_q, s2_q;
   logic             filt_q, filt_d;
   logic             filt_dly_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: defaults first so every path assigns every output -- no latches.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      if (dbnc_i == '0) begin
         filt_d = s2_q;
         cnt_d  = '0;
      end else if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (s2_q == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == dbnc_i - CNT_W'(1)) begin
         filt_d = s2_q;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_q       <= in_i;
         s2_q       <= s1_q;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         cnt_q      <= cnt_d;
      end
   end

   assign filt_o = filt_q;
   assign rise_o = filt_q & ~filt_dly_q;
   assign fall_o = ~filt_q & filt_dly_q;

endmodule

// File: rtl/pio_edge_irq.sv
// Avalon-MM input PIO: debounced inputs, programmable rise/fall edge capture
// into a sticky write-1-to-clear register, and one maskable interrupt.
module pio_edge_irq
   import pio_edge_irq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [BUS_W-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [BUS_W-1:0] readdata,
   output logic             irq
);

   logic [WIDTH-1:0] filt, rise, fall, event_v;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] capt_q, capt_d;
   logic [CNT_W-1:0] dbnc_q, dbnc_d;
   bus_t             rd_q, rd_d;
   logic             wr_en;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      pio_debounce_ch #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .in_i      (in_port[g]),
         .dbnc_i    (dbnc_q),
         .cnt_clr_i (wr_en && address == ADDR_DBNC),
         .filt_o    (filt[g]),
         .rise_o    (rise[g]),
         .fall_o    (fall[g])
      );
   end

   assign event_v = (rise & rise_en_q) | (fall & fall_en_q);

   always_comb begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      mask_d    = mask_q;
      dbnc_d    = dbnc_q;
      capt_d    = capt_q;
      if (wr_en) begin
         case (address)
            ADDR_RISE: rise_en_d = writedata[WIDTH-1:0];
            ADDR_MASK: mask_d    = writedata[WIDTH-1:0];
            ADDR_FALL: fall_en_d = writedata[WIDTH-1:0];
            ADDR_DBNC: dbnc_d    = writedata[CNT_W-1:0];
            ADDR_CAPT: capt_d    = capt_q & ~writedata[WIDTH-1:0];
            default:   ;
         endcase
      end
      // Set after clear: an event coinciding with its clear write survives.
      capt_d = capt_d | event_v;
   end

   always_comb begin
      rd_d = '0;
      case (address)
         ADDR_DATA: rd_d[WIDTH-1:0] = filt;
         ADDR_RISE: rd_d[WIDTH-1:0] = rise_en_q;
         ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
         ADDR_CAPT: rd_d[WIDTH-1:0] = capt_q;
         ADDR_FALL: rd_d[WIDTH-1:0] = fall_en_q;
         ADDR_DBNC: rd_d[CNT_W-1:0] = dbnc_q;
         default:   rd_d = '0;
      endcase
   end

   // NOTE: only flops get reset here; there is no memory array to clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rise_en_q <= '0;
         fall_en_q <= '0;
         mask_q    <= '0;
         capt_q    <= '0;
         dbnc_q    <= '0;
         rd_q      <= '0;
      end else begin
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         mask_q    <= mask_d;
         capt_q    <= capt_d;
         dbnc_q    <= dbnc_d;
         rd_q      <= rd_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = |(capt_q & mask_q);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Self-checking bench for pio_edge_irq: directed scenarios plus random traffic,
// each cycle compared against a behavioural model of the register block.
module tb_pio_edge_irq;
   import pio_edge_irq_pkg::*;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [2:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [W-1:0]  in_port = '0;
   logic [31:0]   readdata;
   logic          irq;

   int n_cmp = 0;
   int n_err = 0;

   pio_edge_irq #(.WIDTH(W), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Reference model state: input history, filtered levels, mismatch run lengths.
   bit [W-1:0] sync_hist[$];
   bit [W-1:0] m_filt, m_filt_prev, m_rise_en, m_fall_en, m_mask, m_capt;
   bit [15:0]  m_dbnc;
   int         m_run[W];
   bit [31:0]  m_rd;
   bit         m_irq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      sync_hist.delete();
      sync_hist.push_back('0);
      sync_hist.push_back('0);
      m_filt = '0; m_filt_prev = '0; m_rise_en = '0; m_fall_en = '0;
      m_mask = '0; m_capt = '0; m_dbnc = '0; m_rd = '0; m_irq = 1'b0;
      for (int c = 0; c < W; c++) m_run[c] = 0;
   endfunction

   // Advance the model by one clock, using the inputs presented at this edge.
   function automatic void model_step();
      bit         wr;
      bit [W-1:0] s2, ev, nf, clr;
      wr = chipselect && !write_n;
      s2 = sync_hist[0];
      ev = (m_filt & ~m_filt_prev & m_rise_en) | (~m_filt & m_filt_prev & m_fall_en);
      nf = m_filt;
      for (int c = 0; c < W; c++) begin
         if (m_dbnc == 0) begin
            nf[c] = s2[c];
            m_run[c] = 0;
         end else if (wr && address == ADDR_DBNC) begin
            m_run[c] = 0;
         end else if (s2[c] != m_filt[c]) begin
            m_run[c]++;
            if (m_run[c] >= int'(m_dbnc)) begin
               nf[c] = s2[c];
               m_run[c] = 0;
            end
         end else begin
            m_run[c] = 0;
         end
      end
      case (address)
         ADDR_DATA: m_rd = {24'b0, m_filt};
         ADDR_RISE: m_rd = {24'b0, m_rise_en};
         ADDR_MASK: m_rd = {24'b0, m_mask};
         ADDR_CAPT: m_rd = {24'b0, m_capt};
         ADDR_FALL: m_rd = {24'b0, m_fall_en};
         ADDR_DBNC: m_rd = {16'b0, m_dbnc};
         default:   m_rd = '0;
      endcase
      clr = (wr && address == ADDR_CAPT) ? writedata[W-1:0] : '0;
      m_capt = (m_capt & ~clr) | ev;
      if (wr) begin
         case (address)
            ADDR_RISE: m_rise_en = writedata[W-1:0];
            ADDR_MASK: m_mask    = writedata[W-1:0];
            ADDR_FALL: m_fall_en = writedata[W-1:0];
            ADDR_DBNC: m_dbnc    = writedata[15:0];
            default:   ;
         endcase
      end
      m_filt_prev = m_filt;
      m_filt = nf;
      sync_hist.push_back(in_port);
      void'(sync_hist.pop_front());
      m_irq = |(m_capt & m_mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("rd_model", readdata, m_rd);
      check("irq_model", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      model_reset();
      #12;
      check("reset_rd", readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Every register reads 0 after reset.
      for (int a = 0; a < 8; a++) begin
         rd_reg(3'(a), d);
         check("reset_reg", d, 32'h0);
      end

      // Bypass mode, rising edge on channel 0.
      wr_reg(ADDR_RISE, 32'h01);
      wr_reg(ADDR_MASK, 32'h01);
      address = ADDR_DATA;
      in_port[0] = 1'b1;
      repeat (3) tick();
      check("irq_before_edge4", {31'b0, irq}, 32'h0);
      tick();
      check("irq_edge4", {31'b0, irq}, 32'h1);
      check("data_ch0", readdata, 32'h01);
      wr_reg(ADDR_CAPT, 32'h01);
      check("irq_after_clear", {31'b0, irq}, 32'h0);
      rd_reg(ADDR_CAPT, d);
      check("capt_after_clear", d, 32'h0);

      // Debounce of 4: a 3-cycle glitch is rejected, a 4-cycle pulse is not.
      wr_reg(ADDR_RISE, 32'h0);
      wr_reg(ADDR_MASK, 32'h0);
      in_port[7] = 1'b1;
      wr_reg(ADDR_DBNC, 32'd4);
      wr_reg(ADDR_FALL, 32'h80);
      idle(10);
      wr_reg(ADDR_CAPT, 32'hFF);
      in_port[7] = 1'b0;
      repeat (3) tick();
      in_port[7] = 1'b1;
      idle(12);
      rd_reg(ADDR_DATA, d);
      check("glitch_data", d, 32'h81);
      rd_reg(ADDR_CAPT, d);
      check("glitch_capt", d, 32'h0);
      in_port[7] = 1'b0;
      repeat (4) tick();
      in_port[7] = 1'b1;
      idle(12);
      rd_reg(ADDR_CAPT, d);
      check("pulse4_capt", d, 32'h80);

      // Both edges enabled, masked interrupt, then unmask.
      wr_reg(ADDR_DBNC, 32'd0);
      wr_reg(ADDR_RISE, 32'h02);
      wr_reg(ADDR_FALL, 32'h02);
      wr_reg(ADDR_CAPT, 32'hFF);
      in_port[1] = 1'b1;
      repeat (3) tick();
      in_port[1] = 1'b0;
      idle(8);
      rd_reg(ADDR_CAPT, d);
      check("both_edges_capt", d, 32'h02);
      check("masked_irq", {31'b0, irq}, 32'h0);
      wr_reg(ADDR_MASK, 32'h02);
      check("unmask_irq", {31'b0, irq}, 32'h1);

      // Clear write lands on the same edge as a channel-2 event.
      wr_reg(ADDR_MASK, 32'h0);
      wr_reg(ADDR_RISE, 32'h04);
      wr_reg(ADDR_FALL, 32'h0);
      wr_reg(ADDR_CAPT, 32'hFF);
      in_port[2] = 1'b1;
      repeat (3) tick();
      wr_reg(ADDR_CAPT, 32'h04);
      rd_reg(ADDR_CAPT, d);
      check("set_wins_clear", d & 32'h04, 32'h04);

      // Reset in the middle of a debounce count, input held high throughout.
      wr_reg(ADDR_CAPT, 32'hFF);
      wr_reg(ADDR_DBNC, 32'd5);
      wr_reg(ADDR_RISE, 32'h08);
      in_port[3] = 1'b1;
      repeat (4) tick();
      reset_n = 1'b0;
      model_reset();
      #1;
      check("midreset_rd", readdata, 32'h0);
      check("midreset_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      wr_reg(ADDR_RISE, 32'h08);
      wr_reg(ADDR_DBNC, 32'd5);
      address = ADDR_CAPT;
      repeat (6) tick();
      check("post_reset_capt_edge8", readdata, 32'h0);
      tick();
      check("post_reset_capt_edge9", readdata, 32'h08);

      // Random register traffic and slowly toggling inputs.
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 7) == 0) in_port[b] = ~in_port[b];
         address    = 3'($urandom_range(0, 7));
         chipselect = ($urandom_range(0, 3) == 0);
         write_n    = 1'($urandom_range(0, 1));
         writedata  = (address == ADDR_DBNC) ? 32'($urandom_range(0, 5)) : $urandom;
         tick();
      end
      chipselect = 1'b0;
      write_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pio_edge_irq.md
# pio_edge_irq

Parametrised multi-channel Avalon-MM PIO input block. It synchronises and debounces each input, then detects programmable rising and/or falling edges into a sticky write-1-to-clear capture register. It drives a single maskable interrupt. It replaces the single-bit rising-edge-only input PIOs in the Main PLD SOPC system, one instance per interrupt-source group.

## Interface
- WIDTH, default 8: number of input channels, 1..32.
- CNT_W, default 16: width of the shared debounce threshold and of each per-channel debounce counter.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low; clock clk.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, one-cycle writes.
- writedata  in  32  write data; bits above WIDTH or CNT_W are ignored.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data; reset 0; unused upper bits read 0.
- irq  out  1  interrupt request, combinational OR of (edge_capture & irq_mask); reset 0.

## Operation
- Register map (word address):
  - 0 DATA: RO, filtered input levels.
  - 1 RISE_EN: RW.
  - 2 IRQ_MASK: RW.
  - 3 EDGE_CAPTURE: RW1C.
  - 4 FALL_EN: RW.
  - 5 DBNC: RW, CNT_W bits.
  - 6, 7: read 0, writes ignored.
- All RW registers reset to 0; DBNC resets to 0, which means bypass.
- Per channel, three stages:
  - Synchroniser: two flops s1 → s2, both reset 0.
  - Filter register filt, reset 0.
    - DBNC = 0: filt ← s2 every cycle.
    - Otherwise, cnt compares s2 with filt:
      - s2 == filt: cnt ← 0.
      - s2 != filt and cnt == DBNC−1: filt ← s2, cnt ← 0.
      - Otherwise: cnt ← cnt+1.
    - A pulse shorter than DBNC cycles at s2 is therefore rejected.
  - Edge stage: filt_d ← filt, reset 0.
    - rise = filt & ~filt_d; fall = ~filt & filt_d.
    - event = (rise & RISE_EN) | (fall & FALL_EN).
    - Both enables set: both edges are captured.
- EDGE_CAPTURE bit update:
  - Write 1 to a bit clears it; write 0 leaves it.
  - A new event on the same cycle as its clear write sets the bit: set wins, no event is lost.
- A write to DBNC clears every cnt on the same edge; filt values are kept.
- Changing RISE_EN or FALL_EN never sets capture bits by itself.
- Reads: readdata ← mux(address) on every clock, regardless of chipselect, as the current system requires. Read side effects: none.

## Timing
- Read latency: 1 clock, i.e. readdata valid on the edge after address is presented.
- Register writes take effect on the edge where chipselect & ~write_n.
- Input step applied before edge 0 with D = max(DBNC, 1):
  - s2 changes at edge 2.
  - filt (DATA) changes at edge 2+D.
  - EDGE_CAPTURE bit and irq assert at edge 3+D.
- irq follows a capture clear or IRQ_MASK write with no added delay after the register edge.
- Reset mid-debounce: all flops clear. An input held high through reset produces a rising event 3+D cycles after release.

## Structure
- Package pio_edge_irq_pkg holds:
  - Address constants: ADDR_DATA=0, ADDR_RISE=1, ADDR_MASK=2, ADDR_CAPT=3, ADDR_FALL=4, ADDR_DBNC=5.
  - Data bus width constant, 32.
- Sub-module pio_debounce_ch covers one channel: synchroniser, cnt, filt and filt_d. It outputs filt, rise and fall, and is instantiated WIDTH times by generate.
- The top module holds the registers, capture logic, read mux and irq.

## Test plan
- Reset, WIDTH=8: all reads return 0, irq=0.
- DBNC=0, RISE_EN=0x01, IRQ_MASK=0x01; raise in_port[0] before edge 0 -> DATA=0x01 after edge 3; capture=0x01 and irq=1 after edge 4; write 0x01 to addr 3 -> capture=0, irq=0.
- DBNC=4, FALL_EN=0x80, in_port[7] preset high and settled:
  - A 3-cycle low glitch -> no change to DATA or capture.
  - A 4-cycle low pulse -> capture=0x80.
- RISE_EN=FALL_EN=0x02, IRQ_MASK=0: pulse in_port[1] -> capture=0x02, irq=0. Then write IRQ_MASK=0x02 -> irq=1 the next cycle.
- Clear write to addr 3 with data 0x04 on the exact cycle a channel-2 event fires -> capture bit 2 remains 1.
- Assert reset_n low mid-debounce (cnt=2, DBNC=5) -> all outputs 0. After release, an input held high produces capture 8 cycles later.
